cvt_row_reader: RTL and testbench
=================================

# cvt_row_reader

Read-side sequencer for the CVT table. On a single start request it walks the selected columns of one CVT row (basic-block index), drives the CVT read port (ReadSel/ReadReg/R_en) one column per cycle, captures the returned 64-bit words, and presents them on a valid/ready stream toward the consumer of thread context. Issue is credit-limited so back-pressure never loses a read word.

## Interface
Parameters:
- RD_LAT, 1: cycles from a CVT read-enable cycle to the cycle ReadData holds that word (1..3)
- FIFO_DEPTH, 4: output buffer entries; must be ≥ RD_LAT+2 for one word/cycle throughput

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  request pulse; accepted only when busy=0
- start_row  in  5  CVT row (BB index) to read
- start_mask  in  16  column select, bit i = read column i
- cvt_R_en  out  1  CVT read enable
- cvt_ReadSel  out  4  CVT column select
- cvt_ReadReg  out  5  CVT row select
- cvt_ReadData  in  64  CVT read data
- out_valid  out  1  stream word valid
- out_ready  in  1  consumer accepts word
- out_data  out  64  word
- out_col  out  4  source column of word
- out_last  out  1  final word of the request
- busy  out  1  request in progress
- done  out  1  one-cycle pulse at request completion

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE: start=1 latches row and mask, busy=1; mask≠0 → ISSUE, mask=0 → done pulse next cycle, back to IDLE, no reads, no beats.
- ISSUE: each cycle, if credit available, issue lowest set remaining mask bit: cvt_R_en=1, ReadSel=column, ReadReg=row; clear that bit. Last bit issued → DRAIN.
- Credit: issue only when fifo_count + inflight < FIFO_DEPTH (same-cycle pop not counted).
- Inflight reads tracked by an RD_LAT-deep shift of {valid, col, last}; at its tail cvt_ReadData is written into the FIFO with col/last tags. FIFO never overflows by construction.
- Column order strictly ascending; out_last=1 only on the highest selected column.
- DRAIN: wait until the out_last beat handshakes (out_valid & out_ready); done=1 the following cycle, busy=0 that same cycle, → IDLE.
- start while busy=1 ignored (no latch, no side effect).
- cvt_R_en=0 except on issue cycles; ReadSel/ReadReg hold last value when idle.
- Stream: out_valid/out_data/out_col/out_last reflect FIFO head; word held stable until accepted; out_valid never drops without handshake.

## Timing
- Reset (async assert, sync release): state IDLE, busy=0, done=0, cvt_R_en=0, cvt_ReadSel=0, cvt_ReadReg=0, out_valid=0, out_data=0, out_col=0, out_last=0, FIFO and inflight cleared. Reset mid-request discards all data; no done pulse.
- start accepted at edge T: first cvt_R_en in cycle T+1; its word sampled at end of cycle T+1+RD_LAT; out_valid first high in cycle T+2+RD_LAT.
- out_ready held high, FIFO_DEPTH ≥ RD_LAT+2: one word per cycle, N selected columns complete in N+RD_LAT+2 cycles from accept to done.
- out_ready low: issue stalls once credits exhausted; resumes the cycle after credit frees.
- done asserted exactly once per accepted start; next start accepted in the cycle done is high.

## Structure
- Package cvt_pkg: CVT_ROWS=32, CVT_COLS=16, CVT_W=64; typedefs cvt_row_t (5b), cvt_col_t (4b), cvt_word_t (64b), cvt_mask_t (16b); FSM state enum.
- One sub-module: cvt_rd_fifo (synchronous FIFO, DEPTH parameter, {word, col, last} payload, count output).
- Priority encoder for lowest set mask bit stays inline.

## Test plan
- Row 3, mask 16'h0005, out_ready=1, model CVT word = {row, col} pattern → beats col 0 then col 2, out_last on col 2, done at accept+5 (RD_LAT=1).
- Mask 16'hFFFF, out_ready=1 → 16 beats back-to-back, cols 0..15 in order, done once.
- Mask 16'hFFFF, out_ready toggled 1-of-3 cycles → no lost/duplicated word, cvt_R_en never issued with fifo_count+inflight=4.
- Mask 16'h0000 → done one cycle after start, cvt_R_en and out_valid never high.
- Second start pulse mid-request (row 7) → ignored; only original row's words appear.
- rst low during 8-word request → all outputs 0 immediately; no done; fresh request after release completes normally.

Source files
------------

// File: rtl/cvt_pkg.sv
// cvt_pkg
//   Shared types and constants for the CVT read-side logic.
//   - CVT geometry: 32 rows (basic-block index) x 16 columns of 64-bit words.
//   - Row/column/word/mask typedefs used on every CVT-facing port.
//   - Reader FSM state encoding.
//   - Tag carried alongside an in-flight read and the FIFO payload record.
package cvt_pkg;

  localparam int CVT_ROWS = 32;
  localparam int CVT_COLS = 16;
  localparam int CVT_W    = 64;

  typedef logic [$clog2(CVT_ROWS)-1:0] cvt_row_t;   // 5 bits
  typedef logic [$clog2(CVT_COLS)-1:0] cvt_col_t;   // 4 bits
  typedef logic [CVT_W-1:0]            cvt_word_t;  // 64 bits
  typedef logic [CVT_COLS-1:0]         cvt_mask_t;  // 16 bits

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } cvt_state_t;

  // Bookkeeping for one read travelling through the CVT read latency.
  typedef struct packed {
    logic     valid;
    cvt_col_t col;
    logic     last;
  } cvt_rd_tag_t;

  // One buffered stream beat.
  typedef struct packed {
    cvt_word_t word;
    cvt_col_t  col;
    logic      last;
  } cvt_beat_t;

endpackage

// File: rtl/cvt_rd_fifo.sv
// cvt_rd_fifo
//   Small synchronous FIFO buffering CVT read words toward the stream
//   consumer. The head entry is presented combinationally so the stream
//   output is valid in the cycle after a word is written.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   push       in   write push_word/push_col/push_last
//   push_*     in   payload {word, col, last}
//   pop        in   remove head entry (ignored when empty)
//   valid      out  FIFO holds at least one entry
//   head_*     out  payload of the head entry
//   count      out  number of entries held
module cvt_rd_fifo
  import cvt_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [63:0]                push_word,
  input  logic [3:0]                 push_col,
  input  logic                       push_last,
  input  logic                       pop,
  output logic                       valid,
  output logic [63:0]                head_word,
  output logic [3:0]                 head_col,
  output logic                       head_last,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  cvt_beat_t      mem_reg [DEPTH];
  logic [PW-1:0]  wr_ptr_reg;
  logic [PW-1:0]  rd_ptr_reg;
  logic [CW-1:0]  count_reg;
  logic           full;
  logic           empty;
  logic           do_push;
  logic           do_pop;
  cvt_beat_t      head;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is only legal when the head leaves the same cycle.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_reg[wr_ptr_reg] <= '{word: push_word, col: push_col, last: push_last};
        wr_ptr_reg          <= ptr_inc(wr_ptr_reg);
      end
      if (do_pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head      = mem_reg[rd_ptr_reg];
  assign valid     = ~empty;
  assign head_word = head.word;
  assign head_col  = head.col;
  assign head_last = head.last;
  assign count     = count_reg;

endmodule

// File: rtl/cvt_row_reader.sv
// cvt_row_reader
//   Read-side sequencer for the CVT table. A start request latches a row and
//   a column mask, then the selected columns are read one per cycle in
//   ascending order. Returned words are buffered and presented on a
//   valid/ready stream; the final word carries out_last. Reads are issued
//   only while the buffer plus the reads still in flight leave room, so
//   consumer back-pressure can never drop a word.
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-low reset
//   start/start_row/mask  request pulse (honoured only while idle)
//   cvt_R_en/ReadSel/Reg  CVT read port request
//   cvt_ReadData          CVT read data, RD_LAT cycles after cvt_R_en
//   out_valid/ready       stream handshake
//   out_data/col/last     stream payload
//   busy                  request in progress
//   done                  one-cycle pulse when the request has completed
module cvt_row_reader
  import cvt_pkg::*;
#(
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [4:0]  start_row,
  input  logic [15:0] start_mask,
  output logic        cvt_R_en,
  output logic [3:0]  cvt_ReadSel,
  output logic [4:0]  cvt_ReadReg,
  input  logic [63:0] cvt_ReadData,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic [3:0]  out_col,
  output logic        out_last,
  output logic        busy,
  output logic        done
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  cvt_state_t  state_reg;
  cvt_state_t  state_next;

  cvt_row_t    row_reg;
  cvt_mask_t   mask_reg;
  cvt_col_t    sel_reg;
  logic        done_reg;

  cvt_col_t    low_col;
  cvt_mask_t   mask_after;
  logic        accept;
  logic        issue;
  logic        credit_ok;
  logic        pop;
  logic        last_hs;
  int          inflight;
  logic [CW-1:0] fifo_count;

  cvt_rd_tag_t issue_tag;
  cvt_rd_tag_t stage_in  [RD_LAT];
  cvt_rd_tag_t stage_reg [RD_LAT];
  logic [RD_LAT-1:0] stage_valid;
  cvt_rd_tag_t tail_tag;

  // ---------------------------------------------------------------------
  // Lowest remaining column. Scanning downward lets the last hit (the
  // lowest index) win without a separate "found" flag.
  // ---------------------------------------------------------------------
  always_comb begin
    low_col = '0;
    for (int i = CVT_COLS - 1; i >= 0; i--) begin
      if (mask_reg[i]) begin
        low_col = cvt_col_t'(i);
      end
    end
  end

  assign mask_after = mask_reg & ~(cvt_mask_t'(1) << low_col);

  // ---------------------------------------------------------------------
  // Credit: words in the FIFO plus reads still in the latency pipe must
  // leave a free slot. A pop in the same cycle is deliberately ignored so
  // the credit path does not depend on out_ready.
  // ---------------------------------------------------------------------
  always_comb begin
    inflight = 0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + int'(stage_valid[i]);
    end
  end

  assign credit_ok = (int'(fifo_count) + inflight) < FIFO_DEPTH;

  assign accept  = (state_reg == IDLE) && start;
  assign pop     = out_valid & out_ready;
  assign last_hs = pop & out_last;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        // An empty mask completes straight from IDLE via the done pulse.
        if (start && (start_mask != '0)) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (issue && (mask_after == '0)) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (last_hs) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    issue       = (state_reg == ISSUE) && credit_ok;
    cvt_R_en    = issue;
    // Column select follows the encoder while issuing and otherwise holds
    // the last column actually read.
    cvt_ReadSel = issue ? low_col : sel_reg;
    busy        = (state_reg != IDLE);
  end

  assign cvt_ReadReg = row_reg;
  assign done        = done_reg;

  // ---------------------------------------------------------------------
  // Request registers and completion pulse
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_reg  <= '0;
      mask_reg <= '0;
      sel_reg  <= '0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= (accept && (start_mask == '0)) ||
                  ((state_reg == DRAIN) && last_hs);
      if (accept) begin
        row_reg  <= start_row;
        mask_reg <= start_mask;
      end else if (issue) begin
        mask_reg <= mask_after;
        sel_reg  <= low_col;
      end
    end
  end

  // ---------------------------------------------------------------------
  // In-flight read pipe: one stage per cycle of CVT read latency. The tag
  // leaving the last stage lines up with the matching cvt_ReadData word.
  // ---------------------------------------------------------------------
  assign issue_tag = '{valid: issue, col: low_col, last: (mask_after == '0)};

  genvar gi;
  generate
    for (gi = 0; gi < RD_LAT; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign stage_in[gi] = issue_tag;
      end else begin : g_next
        assign stage_in[gi] = stage_reg[gi-1];
      end
      assign stage_valid[gi] = stage_reg[gi].valid;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        stage_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < RD_LAT; i++) begin
        stage_reg[i] <= stage_in[i];
      end
    end
  end

  assign tail_tag = stage_reg[RD_LAT-1];

  // ---------------------------------------------------------------------
  // Output buffer. Credit accounting guarantees a free slot for every
  // word arriving at the tail of the read pipe.
  // ---------------------------------------------------------------------
  cvt_rd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tail_tag.valid),
    .push_word (cvt_ReadData),
    .push_col  (tail_tag.col),
    .push_last (tail_tag.last),
    .pop       (pop),
    .valid     (out_valid),
    .head_word (out_data),
    .head_col  (out_col),
    .head_last (out_last),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_cvt_row_reader.sv
// Directed testbench for cvt_row_reader (RD_LAT=1, FIFO_DEPTH=4).
// A behavioural CVT returns {16'hC0DE, 3'b0, row, 8'h5A, 28'b0, col} one
// cycle after each read enable. A negedge monitor logs every accepted beat.
module tb_cvt_row_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  start_row = '0;
  logic [15:0] start_mask = '0;
  logic        cvt_R_en;
  logic [3:0]  cvt_ReadSel;
  logic [4:0]  cvt_ReadReg;
  logic [63:0] cvt_ReadData = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic [3:0]  out_col;
  logic        out_last;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  col;
    logic        last;
    int          cyc;
  } beat_t;

  beat_t beats[$];
  int    exp_q[$];
  int    rd_count, hs_count, done_count, done_cyc;
  int    first_ren, first_valid, valid_seen;
  int    credit_viol, stab_viol, max_out;
  bit    prev_pend;
  logic [63:0] prev_data;
  logic [3:0]  prev_col;
  logic        prev_last;

  cvt_row_reader #(.RD_LAT(1), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .start_row    (start_row),
    .start_mask   (start_mask),
    .cvt_R_en     (cvt_R_en),
    .cvt_ReadSel  (cvt_ReadSel),
    .cvt_ReadReg  (cvt_ReadReg),
    .cvt_ReadData (cvt_ReadData),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_col      (out_col),
    .out_last     (out_last),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [63:0] cvt_word(input logic [4:0] r, input logic [3:0] c);
    return {16'hC0DE, 3'b000, r, 8'h5A, 28'd0, c};
  endfunction

  // Behavioural CVT read port, one cycle of latency.
  always @(posedge clk) begin
    if (cvt_R_en) cvt_ReadData <= cvt_word(cvt_ReadReg, cvt_ReadSel);
  end

  // Monitor: outstanding = reads issued minus beats accepted in earlier cycles.
  always @(negedge clk) begin
    if (!rst) begin
      prev_pend = 1'b0;
    end else begin
      if (prev_pend && (!out_valid || out_data !== prev_data ||
                        out_col !== prev_col || out_last !== prev_last))
        stab_viol++;
      if (cvt_R_en) begin
        if (rd_count - hs_count >= 4) credit_viol++;
        if (rd_count - hs_count + 1 > max_out) max_out = rd_count - hs_count + 1;
        if (first_ren < 0) first_ren = cyc;
        rd_count++;
      end
      if (out_valid) begin
        valid_seen++;
        if (first_valid < 0) first_valid = cyc;
      end
      if (out_valid && out_ready) begin
        beats.push_back('{data: out_data, col: out_col, last: out_last, cyc: cyc});
        hs_count++;
        $display("beat  cyc=%0d col=%0d last=%0b data=%h", cyc, out_col, out_last, out_data);
      end
      if (done) begin
        done_count++;
        done_cyc = cyc;
        $display("done  cyc=%0d", cyc);
      end
      prev_pend = out_valid && !out_ready;
      prev_data = out_data;
      prev_col  = out_col;
      prev_last = out_last;
    end
  end

  task automatic clear_mon();
    beats.delete();
    rd_count = 0; hs_count = 0; done_count = 0; done_cyc = -1;
    first_ren = -1; first_valid = -1; valid_seen = 0;
    credit_viol = 0; stab_viol = 0; max_out = 0;
  endtask

  task automatic build_exp(input logic [15:0] m);
    exp_q.delete();
    for (int c = 0; c < 16; c++) if (m[c]) exp_q.push_back(c);
  endtask

  // Called just after a rising edge; returns just after the edge that samples start.
  task automatic pulse_start(input logic [4:0] r, input logic [15:0] m, output int acc);
    start = 1'b1; start_row = r; start_mask = m;
    @(posedge clk); #1;
    acc = cyc;
    start = 1'b0;
    $display("start row=%0d mask=%h accepted_at=%0d", r, m, acc);
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (done_count > 0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #2;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b want=0", done); end
    n_checks++; if (cvt_R_en !== 1'b0) begin n_fail++; $display("FAIL reset_ren got=%b want=0", cvt_R_en); end
    n_checks++; if (cvt_ReadSel !== 4'd0) begin n_fail++; $display("FAIL reset_sel got=%h want=0", cvt_ReadSel); end
    n_checks++; if (cvt_ReadReg !== 5'd0) begin n_fail++; $display("FAIL reset_reg got=%h want=0", cvt_ReadReg); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    n_checks++; if (out_data !== 64'd0) begin n_fail++; $display("FAIL reset_data got=%h want=0", out_data); end
    n_checks++; if ({out_col, out_last} !== 5'd0) begin n_fail++; $display("FAIL reset_col_last got=%h want=0", {out_col, out_last}); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    idle_cycles(2);
  endtask

  task automatic test_two_cols();
    int acc; bit ok;
    clear_mon(); out_ready = 1'b1;
    build_exp(16'h0005);
    pulse_start(5'd3, 16'h0005, acc);
    wait_done(30, ok);
    idle_cycles(3);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL two_timeout got=no_done want=done"); end
    n_checks++; if (beats.size() != 2) begin n_fail++; $display("FAIL two_count got=%0d want=2", beats.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= beats.size()) begin n_fail++; $display("FAIL two_beat%0d got=missing want=col%0d", i, exp_q[i]); end
      else if (beats[i].col !== 4'(exp_q[i]) || beats[i].data !== cvt_word(5'd3, 4'(exp_q[i])) ||
               beats[i].last !== (i == exp_q.size() - 1)) begin
        n_fail++; $display("FAIL two_beat%0d got=col%0d/%b/%h want=col%0d", i, beats[i].col, beats[i].last, beats[i].data, exp_q[i]);
      end
    end
    n_checks++; if (first_ren - acc != 0) begin n_fail++; $display("FAIL two_first_ren got=+%0d want=+0", first_ren - acc); end
    n_checks++; if (first_valid - acc != 2) begin n_fail++; $display("FAIL two_first_valid got=+%0d want=+2", first_valid - acc); end
    n_checks++; if (done_cyc - acc != 4) begin n_fail++; $display("FAIL two_done_time got=+%0d want=+4", done_cyc - acc); end
    n_checks++; if (done_count != 1) begin n_fail++; $display("FAIL two_done_count got=%0d want=1", done_count); end
    n_checks++; if (rd_count != 2) begin n_fail++; $display("FAIL two_reads got=%0d want=2", rd_count); end
    n_checks++; if ({cvt_ReadReg, cvt_ReadSel} !== {5'd3, 4'd2}) begin n_fail++; $display("FAIL two_hold got=%h/%h want=3/2", cvt_ReadReg, cvt_ReadSel); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL two_busy got=%b want=0", busy); end
  endtask

  task automatic test_full_mask();
    int acc; bit ok;
    clear_mon(); out_ready = 1'b1;
    build_exp(16'hFFFF);
    pulse_start(5'd9, 16'hFFFF, acc);
    wait_done(60, ok);
    idle_cycles(3);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL full_timeout got=no_done want=done"); end
    n_checks++; if (beats.size() != 16) begin n_fail++; $display("FAIL full_count got=%0d want=16", beats.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= beats.size()) begin n_fail++; $display("FAIL full_beat%0d got=missing want=col%0d", i, exp_q[i]); end
      else if (beats[i].col !== 4'(exp_q[i]) || beats[i].data !== cvt_word(5'd9, 4'(exp_q[i])) ||
               beats[i].last !== (i == exp_q.size() - 1) || beats[i].cyc - acc != i + 2) begin
        n_fail++; $display("FAIL full_beat%0d got=col%0d/%b/%h at+%0d want=col%0d at+%0d", i, beats[i].col, beats[i].last, beats[i].data, beats[i].cyc - acc, exp_q[i], i + 2);
      end
    end
    n_checks++; if (done_cyc - acc != 18) begin n_fail++; $display("FAIL full_done_time got=+%0d want=+18", done_cyc - acc); end
    n_checks++; if (done_count != 1) begin n_fail++; $display("FAIL full_done_count got=%0d want=1", done_count); end
  endtask

  task automatic test_backpressure();
    int acc; bit ok; int k;
    clear_mon(); out_ready = 1'b0;
    build_exp(16'hFFFF);
    pulse_start(5'd12, 16'hFFFF, acc);
    ok = 1'b0; k = 0;
    while (k < 200 && !ok) begin
      @(posedge clk); #1;
      out_ready = (k % 3 == 2);
      k++;
      if (done_count > 0) ok = 1'b1;
    end
    out_ready = 1'b1;
    idle_cycles(3);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_timeout got=no_done want=done"); end
    n_checks++; if (beats.size() != 16) begin n_fail++; $display("FAIL bp_count got=%0d want=16", beats.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= beats.size()) begin n_fail++; $display("FAIL bp_beat%0d got=missing want=col%0d", i, exp_q[i]); end
      else if (beats[i].col !== 4'(exp_q[i]) || beats[i].data !== cvt_word(5'd12, 4'(exp_q[i])) ||
               beats[i].last !== (i == exp_q.size() - 1)) begin
        n_fail++; $display("FAIL bp_beat%0d got=col%0d/%b/%h want=col%0d", i, beats[i].col, beats[i].last, beats[i].data, exp_q[i]);
      end
    end
    n_checks++; if (credit_viol != 0) begin n_fail++; $display("FAIL bp_credit got=%0d issues_at_4 want=0", credit_viol); end
    n_checks++; if (max_out != 4) begin n_fail++; $display("FAIL bp_max_outstanding got=%0d want=4", max_out); end
    n_checks++; if (stab_viol != 0) begin n_fail++; $display("FAIL bp_stable got=%0d violations want=0", stab_viol); end
    n_checks++; if (done_count != 1) begin n_fail++; $display("FAIL bp_done_count got=%0d want=1", done_count); end
  endtask

  task automatic test_empty_mask();
    int acc; bit ok;
    clear_mon(); out_ready = 1'b1;
    pulse_start(5'd4, 16'h0000, acc);
    wait_done(10, ok);
    idle_cycles(5);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL empty_timeout got=no_done want=done"); end
    n_checks++; if (done_cyc - acc != 0) begin n_fail++; $display("FAIL empty_done_time got=+%0d want=+0", done_cyc - acc); end
    n_checks++; if (done_count != 1) begin n_fail++; $display("FAIL empty_done_count got=%0d want=1", done_count); end
    n_checks++; if (rd_count != 0) begin n_fail++; $display("FAIL empty_reads got=%0d want=0", rd_count); end
    n_checks++; if (valid_seen != 0) begin n_fail++; $display("FAIL empty_valid got=%0d want=0", valid_seen); end
  endtask

  task automatic test_back_to_back();
    int acc; bit seen; bit ok;
    clear_mon(); out_ready = 1'b1;
    pulse_start(5'd1, 16'h8000, acc);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) begin seen = 1'b1; break; end
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL b2b_first_done got=none want=pulse"); end
    // Start issued in the very cycle done is high.
    pulse_start(5'd2, 16'h0102, acc);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept got=busy%b want=busy1", busy); end
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done_count >= 2) begin ok = 1'b1; break; end
    end
    idle_cycles(3);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_timeout got=no_done want=done"); end
    n_checks++; if (beats.size() != 3) begin n_fail++; $display("FAIL b2b_count got=%0d want=3", beats.size()); end
    n_checks++;
    if (beats.size() < 3 || beats[0].data !== cvt_word(5'd1, 4'd15) || beats[0].last !== 1'b1 ||
        beats[1].data !== cvt_word(5'd2, 4'd1) || beats[1].last !== 1'b0 ||
        beats[2].data !== cvt_word(5'd2, 4'd8) || beats[2].col !== 4'd8 || beats[2].last !== 1'b1) begin
      n_fail++; $display("FAIL b2b_beats got=%0d beats, wrong content want=r1c15L,r2c1,r2c8L", beats.size());
    end
    n_checks++; if (done_count != 2) begin n_fail++; $display("FAIL b2b_done_count got=%0d want=2", done_count); end
  endtask

  task automatic test_ignored_start();
    int acc; bit ok;
    clear_mon(); out_ready = 1'b1;
    build_exp(16'h00F0);
    pulse_start(5'd5, 16'h00F0, acc);
    idle_cycles(1);
    start = 1'b1; start_row = 5'd7; start_mask = 16'h0003;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(30, ok);
    idle_cycles(6);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL ign_timeout got=no_done want=done"); end
    n_checks++; if (beats.size() != 4) begin n_fail++; $display("FAIL ign_count got=%0d want=4", beats.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= beats.size()) begin n_fail++; $display("FAIL ign_beat%0d got=missing want=col%0d", i, exp_q[i]); end
      else if (beats[i].col !== 4'(exp_q[i]) || beats[i].data !== cvt_word(5'd5, 4'(exp_q[i])) ||
               beats[i].last !== (i == exp_q.size() - 1)) begin
        n_fail++; $display("FAIL ign_beat%0d got=col%0d/%b/%h want=col%0d", i, beats[i].col, beats[i].last, beats[i].data, exp_q[i]);
      end
    end
    n_checks++; if (done_count != 1) begin n_fail++; $display("FAIL ign_done_count got=%0d want=1", done_count); end
    n_checks++; if (rd_count != 4) begin n_fail++; $display("FAIL ign_reads got=%0d want=4", rd_count); end
  endtask

  task automatic test_reset_mid();
    int acc; bit ok;
    clear_mon(); out_ready = 1'b0;
    pulse_start(5'd11, 16'h00FF, acc);
    idle_cycles(3);
    n_checks++; if (out_valid !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre got=v%b/b%b want=v1/b1", out_valid, busy); end
    #2 rst = 1'b0;
    #1;
    n_checks++; if ({busy, done, cvt_R_en, out_valid, out_last} !== 5'b0) begin n_fail++; $display("FAIL rstmid_ctrl got=%b want=00000", {busy, done, cvt_R_en, out_valid, out_last}); end
    n_checks++; if (out_data !== 64'd0 || out_col !== 4'd0) begin n_fail++; $display("FAIL rstmid_data got=%h/%h want=0/0", out_data, out_col); end
    n_checks++; if (cvt_ReadSel !== 4'd0 || cvt_ReadReg !== 5'd0) begin n_fail++; $display("FAIL rstmid_port got=%h/%h want=0/0", cvt_ReadSel, cvt_ReadReg); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    idle_cycles(3);
    n_checks++; if (done_count != 0) begin n_fail++; $display("FAIL rstmid_no_done got=%0d want=0", done_count); end
    clear_mon(); out_ready = 1'b1;
    pulse_start(5'd2, 16'h0011, acc);
    wait_done(30, ok);
    idle_cycles(3);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rstmid_timeout got=no_done want=done"); end
    n_checks++;
    if (beats.size() != 2 || beats[0].data !== cvt_word(5'd2, 4'd0) || beats[0].last !== 1'b0 ||
        beats[1].data !== cvt_word(5'd2, 4'd4) || beats[1].col !== 4'd4 || beats[1].last !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_fresh got=%0d beats, wrong content want=r2c0,r2c4L", beats.size());
    end
    n_checks++; if (done_cyc - acc != 4) begin n_fail++; $display("FAIL rstmid_done_time got=+%0d want=+4", done_cyc - acc); end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_two_cols();
    test_full_mask();
    test_backpressure();
    test_empty_mask();
    test_back_to_back();
    test_ignored_start();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
